// File: rtl/four_lane_stream_demux.sv
// Four-lane pixel stream demultiplexer.
// Whole lines go to one lane, chosen in fixed or round-robin mode.
module four_lane_stream_demux #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  input  logic                mode,
  input  logic [1:0]          fixed_sel,
  output logic [4*DATA_W-1:0] out_data,
  output logic [3:0]          out_last,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [1:0]          cur_lane,
  output logic [15:0]         line_count
);

  typedef enum logic {
    IDLE,
    IN_LINE
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [1:0] lane_q;
  logic [1:0] rr_q;
  logic       mode_q;
  logic [1:0] tgt;
  logic       line_mode;
  logic       accept;

  // Lane and mode are frozen for the rest of a line once it starts.
  always_comb begin
    tgt       = mode ? rr_q : fixed_sel;
    line_mode = mode;
    if (state_q == IN_LINE) begin
      tgt       = lane_q;
      line_mode = mode_q;
    end
  end

  assign cur_lane = tgt;
  assign in_ready = rst_n & (~out_valid[tgt] | out_ready[tgt]);
  assign accept   = in_valid & in_ready;

  // Next-state logic: track whether we are between lines or inside one.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = in_last ? IDLE : IN_LINE;
    end
  end

  // Line bookkeeping: FSM, captured lane, round-robin pointer, line count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lane_q     <= 2'd0;
      mode_q     <= 1'b0;
      rr_q       <= 2'd0;
      line_count <= 16'd0;
    end else begin
      state_q <= state_d;
      if (accept && state_q == IDLE) begin
        lane_q <= tgt;
        mode_q <= mode;
      end
      if (accept && in_last) begin
        line_count <= line_count + 16'd1;
        if (line_mode) begin
          rr_q <= rr_q + 2'd1;
        end
      end
    end
  end

  // Per-lane one-entry output registers; a load wins over a drain.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_last  <= '0;
      out_valid <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (accept && tgt == 2'(k)) begin
          out_data[k*DATA_W +: DATA_W] <= in_data;
          out_last[k]                  <= in_last;
          out_valid[k]                 <= 1'b1;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_four_lane_stream_demux.sv
// Scoreboard bench for four_lane_stream_demux.
// Line-level reference model feeds per-lane expected queues.
module tb_four_lane_stream_demux;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_valid = 1'b0;
  logic           in_last = 1'b0;
  logic           in_ready;
  logic           mode = 1'b0;
  logic [1:0]     fixed_sel = 2'd0;
  logic [4*W-1:0] out_data;
  logic [3:0]     out_last;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready = 4'hF;
  logic [1:0]     cur_lane;
  logic [15:0]    line_count;

  four_lane_stream_demux #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready),
    .mode(mode), .fixed_sel(fixed_sel),
    .out_data(out_data), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .cur_lane(cur_lane), .line_count(line_count)
  );

  always #5 clk = ~clk;

  logic [W:0]  q[4][$];
  logic [3:0]  fresh = '0;
  bit          in_line;
  bit          line_mode;
  logic [1:0]  line_lane;
  logic [1:0]  rr;
  logic [15:0] lc;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented lane beat with the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        bit expv;
        expv = q[k].size() > int'(fresh[k]);
        check($sformatf("valid%0d", k), 32'(out_valid[k]), 32'(expv));
        if (out_valid[k] && expv) begin
          check($sformatf("data%0d", k),
                32'(out_data[k*W +: W]), 32'(q[k][0][W-1:0]));
          check($sformatf("last%0d", k),
                32'(out_last[k]), 32'(q[k][0][W]));
          if (out_ready[k]) void'(q[k].pop_front());
        end
      end
    end
  end

  task automatic model_clear();
    for (int k = 0; k < 4; k++) q[k].delete();
    fresh     = '0;
    in_line   = 0;
    line_mode = 0;
    line_lane = 2'd0;
    rr        = 2'd0;
    lc        = 16'd0;
  endtask

  // One clock of stimulus plus the model's view of that cycle.
  task automatic cyc(input logic v, input logic l,
                     input logic [W-1:0] d, input logic m,
                     input logic [1:0] s, input logic [3:0] r);
    logic [1:0] t;
    bit         rdy;
    @(posedge clk);
    #1;
    fresh     = '0;
    in_valid  = v;
    in_last   = l;
    in_data   = d;
    mode      = m;
    fixed_sel = s;
    out_ready = r;
    #1;
    t   = in_line ? line_lane : (m ? rr : s);
    rdy = (q[t].size() == 0) || r[t];
    check("in_ready", 32'(in_ready), 32'(rdy));
    check("cur_lane", 32'(cur_lane), 32'(t));
    check("line_count", 32'(line_count), 32'(lc));
    if (v && rdy) begin
      q[t].push_back({l, d});
      fresh[t] = 1'b1;
      if (!in_line) begin
        line_lane = t;
        line_mode = m;
      end
      if (l) begin
        lc++;
        if (line_mode) rr++;
        in_line = 0;
      end else begin
        in_line = 1;
      end
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 4'hF;
      #1;
      check("rst_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    model_clear();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    mode     = 1'b1;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_lane", 32'(cur_lane), 32'd0);
    check("rst_count", 32'(line_count), 32'd0);
    check("rst_rdy1", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_clear();
    do_reset(2);

    // Round-robin: four 3-beat lines on lanes 0..3.
    for (int i = 0; i < 12; i++)
      cyc(1, (i % 3) == 2, 8'(8'h10 + i), 1, 2'd3, 4'hF);
    cyc(0, 0, 0, 1, 2'd0, 4'hF);
    check("rr_count4", 32'(line_count), 32'd4);
    check("rr_wrap", 32'(cur_lane), 32'd0);

    // Fixed lane 2; select moves to 1 mid-line.
    cyc(1, 0, 8'h20, 0, 2'd2, 4'hF);
    cyc(1, 0, 8'h21, 0, 2'd2, 4'hF);
    cyc(1, 0, 8'h22, 0, 2'd1, 4'hF);
    check("fix_hold", 32'(cur_lane), 32'd2);
    cyc(1, 0, 8'h23, 0, 2'd1, 4'hF);
    cyc(1, 1, 8'h24, 0, 2'd1, 4'hF);
    cyc(1, 1, 8'h25, 0, 2'd1, 4'hF);
    check("fix_next", 32'(cur_lane), 32'd1);

    // Backpressure on lane 1.
    cyc(0, 0, 0, 0, 2'd1, 4'hF);
    for (int i = 0; i < 4; i++) begin
      cyc(1, i == 3, 8'(8'h30 + i), 0, 2'd1, 4'b1101);
      if (i > 0) check("bp_stall", 32'(in_ready), 32'd0);
    end
    for (int i = 0; i < 4; i++)
      cyc(1, i == 3, 8'(8'h40 + i), 0, 2'd1, 4'hF);

    // Back-to-back drain and load on lane 0.
    for (int i = 0; i < 6; i++)
      cyc(1, i == 5, 8'(8'h50 + i), 0, 2'd0, 4'hF);

    // Reset on the second beat, then a single-beat line.
    cyc(1, 0, 8'h60, 1, 2'd2, 4'hF);
    do_reset(1);
    cyc(1, 1, 8'h61, 1, 2'd3, 4'hF);
    cyc(0, 0, 0, 1, 2'd3, 4'hF);
    check("sb_lane", 32'(cur_lane), 32'd1);
    check("sb_count", 32'(line_count), 32'd1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset(1);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
          W'($urandom), 1'($urandom), 2'($urandom),
          $urandom_range(0, 1) ? 4'hF : 4'($urandom));
    end

    // line_count wrap after 65536 single-beat lines.
    do_reset(1);
    for (int i = 0; i < 65536; i++)
      cyc(1, 1, W'(i), 0, 2'($urandom), 4'hF);
    cyc(0, 0, 0, 0, 2'd0, 4'hF);
    check("wrap_count", 32'(line_count), 32'd0);

    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 2'd0, 4'hF);
    for (int k = 0; k < 4; k++)
      check($sformatf("drained%0d", k), 32'(q[k].size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/four_lane_stream_demux.md
FOUR_LANE_STREAM_DEMUX -- requirements
Module: four_lane_stream_demux

Interface
REQ-001 Parameter DATA_W, default 8: width of one pixel beat, in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-004 in_data  input  DATA_W  upstream pixel beat.
REQ-005 in_valid  input  1  upstream beat present.
REQ-006 in_last  input  1  beat is the last pixel of a line.
REQ-007 in_ready  output  1  block accepts the beat this cycle.
REQ-008 mode  input  1  0 = fixed lane, 1 = round-robin per line.
REQ-009 fixed_sel  input  2  target lane in fixed mode.
REQ-010 out_data  output  4*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
REQ-011 out_last  output  4  per-lane end-of-line flag.
REQ-012 out_valid  output  4  per-lane beat present.
REQ-013 out_ready  input  4  per-lane downstream ready.
REQ-014 cur_lane  output  2  lane receiving the current or next line.
REQ-015 line_count  output  16  number of lines completed since reset.

Function
REQ-016 Accept = in_valid && in_ready.
- A line is a run of accepted beats ending with an accepted beat that has in_last=1.
REQ-017 Two-state FSM:
- IDLE (between lines) -> IN_LINE on an accepted beat with in_last=0.
- IN_LINE -> IDLE on an accepted beat with in_last=1.
- IDLE -> IDLE on an accepted beat with in_last=1 (single-beat line).
REQ-018 Lane selection for a line is decided at the first beat of the line, from mode and fixed_sel sampled in the cycle that beat is accepted while in IDLE.
- fixed_sel and mode changes while IN_LINE are ignored until the next IDLE.
REQ-019 The target lane t is:
- fixed_sel when mode=0;
- the round-robin pointer when mode=1.
- cur_lane presents t while IN_LINE, and the value t would take while IDLE.
REQ-020 Round-robin pointer:
- resets to 0;
- advances by 1 mod 4 (3->0 wrap) on each accepted in_last beat of a line routed in mode=1;
- is unchanged by lines routed in mode=0.
REQ-021 Each lane has a one-entry output register.
- On accept, lane t loads in_data and in_last and sets out_valid[t] on the next edge.
- Latency input to output is 1 cycle.
REQ-022 in_ready = !out_valid[t] || out_ready[t], computed combinationally.
- in_ready is independent of in_valid.
REQ-023 Lane k clears out_valid[k] when out_ready[k]=1 and the lane is not loaded in that same cycle.
- A simultaneous drain and load on the same lane leaves out_valid[k]=1 holding the new beat.
REQ-024 Non-target lanes hold their data, last and valid values and drain independently via their own out_ready.
REQ-025 out_data[k] and out_last[k] remain stable while out_valid[k]=1 and out_ready[k]=0.
REQ-026 line_count increments by 1 on each accepted in_last beat and wraps 0xFFFF->0x0000.
REQ-027 When in_valid=0, no lane is loaded and the FSM holds; out_ready activity on any lane is still honoured.

Reset
REQ-028 While rst_n=0 at a clock edge, the block sets:
- out_valid=0, out_data=0, out_last=0;
- FSM=IDLE, round-robin pointer=0, cur_lane=0, line_count=0.
REQ-029 Reset asserted mid-line discards all buffered beats and the partial line, with no partial-line bookkeeping retained.
REQ-030 in_ready is 0 during reset; the first accept is possible in the first cycle after rst_n returns to 1.

Verification
REQ-031 Round-robin routing:
- Stimulus: mode=1, all out_ready=1, four lines of 3 beats (data 0x10..0x1B).
- Response: lanes 0,1,2,3 each receive 3 beats, each arriving 1 cycle after accept; last flag on the third beat; line_count=4; cur_lane=0 after the wrap.
REQ-032 Fixed mode with mid-line select change:
- Stimulus: mode=0, fixed_sel=2 at line start; fixed_sel changed to 1 mid-line; 5-beat line.
- Response: all 5 beats appear on lane 2; the next line goes to lane 1.
REQ-033 Backpressure on the target lane:
- Stimulus: target lane 1, out_ready[1]=0 for 4 cycles.
- Response: in_ready=0 after one buffered beat; out_data[1] is stable throughout; beat order is preserved once out_ready[1]=1.
REQ-034 Simultaneous drain and load:
- Stimulus: out_valid[0]=1, out_ready[0]=1 and a new accept to lane 0 in the same cycle.
- Response: out_valid[0] stays 1 and holds the new beat; no bubble, no loss.
REQ-035 Reset mid-line and single-beat line:
- Stimulus: rst_n=0 on the 2nd beat of a line, then release.
- Response: all outputs zero and cur_lane=0.
- Stimulus: then a single beat with in_last=1 in mode=1.
- Response: routed to lane 0; cur_lane becomes 1; line_count=1.
REQ-036 line_count wrap:
- Stimulus: drive 65536 single-beat lines.
- Response: line_count returns to 0x0000.
